ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares one `simple_ram` instance between two requesters, e.g. instruction fetch and load/store. Each port uses a req/gnt handshake. The block grants one access per cycle with bounded-burst round-robin fairness, drives the RAM address, write-data and write-enable, and routes the RAM's one-cycle-latency read data back to the port that issued the read with a `rvalid` strobe.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; must match the attached RAM.
- `DATA_WIDTH`, 32, RAM data width.
- `MAX_BURST`, 4, max consecutive grants to one port while the other is requesting; legal range ≥ 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request; held with its fields stable until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH  access address.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; an access transfers in a cycle with req & gnt.
- `p0_rvalid`, `p1_rvalid`  out  1  registered; high one cycle after an accepted read.
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH  read data, qualified by the port's rvalid.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_wdata`  out  DATA_WIDTH  to RAM `wdata`.
- `ram_we`  out  1  to RAM `we`.
- `ram_rdata`  in  DATA_WIDTH  from RAM `rdata`.

## Operation
- State registers:
  - `last`: port granted most recently.
  - `cnt`: consecutive-grant count, width $clog2(MAX_BURST+1), saturates at MAX_BURST.
  - `rd_pend[1:0]`: read issued last cycle, per port.
- Winner selection (combinational, from registered state):
  - Neither req: no grant.
  - Exactly one req: that port wins, regardless of `cnt`.
  - Both req: winner = `last` if `cnt < MAX_BURST`, else the other port.
- Grants are one-hot: `pN_gnt = (winner == N)`. Both grants are never high together.
- RAM drive:
  - Granted cycle: `ram_addr`, `ram_wdata` and `ram_we` come from the winner's fields.
  - No-grant cycle: `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- State update on a grant:
  - Winner == `last`: `cnt <= min(cnt+1, MAX_BURST)`.
  - Otherwise: `last <= winner`, `cnt <= 1`.
- State update on a no-grant cycle: `cnt <= MAX_BURST`, so the next tie goes to the other port; `last` is unchanged.
- Read response:
  - A granted read sets `rd_pend[N]`; next cycle `pN_rvalid=1`.
  - `p0_rdata` and `p1_rdata` are both wired to `ram_rdata`.
- Writes produce no rvalid. The RAM returns the old contents on a write cycle; that data is never flagged valid.
- Back-to-back accesses: a new access can be granted every cycle. A read granted in cycle N+1 overlaps the rvalid of a read granted in cycle N.
- Same-address write (cycle N) then read (cycle N+1) returns the new data in cycle N+2.
- A port dropping req before gnt is permitted; nothing is issued for it.

## Timing
- Reset values: `last=1`, `cnt=MAX_BURST`, `rd_pend=0`.
- Outputs during reset: `p0_rvalid=p1_rvalid=0`. Grants are still computed from inputs, but state is held at reset values.
- First tie after reset goes to port 0.
- Read latency: req&gnt in cycle N → rvalid and data in cycle N+1, exactly 1 cycle.
- Throughput: 1 access/cycle.
- Fairness:
  - Under continuous contention, grant pattern is MAX_BURST to one port, then MAX_BURST to the other.
  - With MAX_BURST=1, grants strictly alternate.
- Reset mid-operation: a read granted in the cycle `rst` rises still has RAM side effects, but its `rvalid` is suppressed. `rd_pend` clears and no rvalid appears after reset deasserts.
- Write granted during a reset cycle still reaches the RAM (`ram_we` is not gated by `rst`). Benches must not rely on writes during reset.
- `cnt` saturation: a lone requester can be granted indefinitely; `cnt` stays at MAX_BURST. When the other port requests, it wins the next tie immediately.

## Test plan
- Reset, then `p0_req=p1_req=1` (reads, addr 3 and 5) every cycle with MAX_BURST=4 → `p0_gnt` cycles 1-4, `p1_gnt` cycles 5-8, `p0_gnt` cycles 9-12; grants never overlap.
- `p0` write addr 0x10 data 0xDEADBEEF in cycle N, `p0` read addr 0x10 in cycle N+1 → `p0_rvalid=1`, `p0_rdata=0xDEADBEEF` in cycle N+2; `p1_rvalid=0` throughout.
- Alternating reads: p1 addr 7 in cycle N, p0 addr 8 in cycle N+1 → `p1_rvalid` in N+1 with mem[7], `p0_rvalid` in N+2 with mem[8]; no rvalid on write-only cycles.
- Only `p1_req` held for 10 cycles → `p1_gnt` all 10 cycles. Then `p0_req` rises → `p0` granted on the next tie cycle.
- Read granted in cycle N with `rst=1` in cycle N+1 → `p0_rvalid=p1_rvalid=0` in N+1 and N+2. After reset, the first tie grants port 0.
- MAX_BURST=1, both requesting continuously for 6 cycles → grant sequence p0,p1,p0,p1,p0,p1. One idle cycle then a tie → the port not granted last wins.

Source files
------------

// File: rtl/ram_arbiter_if.sv
`timescale 1ns/1ps
// ram_arbiter_if
// Bundles the two requester ports and the RAM-side signals of the
// two-port RAM arbiter.
//   slave  : arbiter view. It takes the requests and RAM read data, and
//            drives the grants, read responses and RAM controls.
//   master : environment view. It drives the requests and RAM read data.
// Per-port signals: req, we, addr, wdata, gnt, rvalid, rdata.
// RAM signals: ram_addr, ram_wdata, ram_we, ram_rdata.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  p0_req;
   logic                  p0_we;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic                  p0_gnt;
   logic                  p0_rvalid;
   logic [DATA_WIDTH-1:0] p0_rdata;

   logic                  p1_req;
   logic                  p1_we;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_gnt;
   logic                  p1_rvalid;
   logic [DATA_WIDTH-1:0] p1_rdata;

   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  ram_rdata,
      output p0_gnt, p0_rvalid, p0_rdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output ram_addr, ram_wdata, ram_we
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output ram_rdata,
      input  p0_gnt, p0_rvalid, p0_rdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter
// Shares one single-port RAM between two req/gnt requesters. It grants at
// most one access per cycle, with round-robin fairness over bounded bursts.
// Read data comes back one cycle after the grant and is flagged by the
// issuing port's rvalid.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : ram_arbiter_if.slave. It carries both requester ports and the
//         RAM addr/wdata/we/rdata.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  bus
);
   localparam int             CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   logic          last_r;      // port granted most recently
   logic [CW-1:0] cnt_r;       // consecutive grants to last_r, saturating
   logic [1:0]    rd_pend_r;   // read accepted last cycle, per port

   logic          any_s;       // at least one port is requesting
   logic          winner_s;    // port selected this cycle, valid when any_s

   // Winner selection. A lone requester always wins. On a tie, last_r keeps
   // the grant until its burst budget is used up.
   always_comb begin
      any_s    = bus.p0_req | bus.p1_req;
      winner_s = 1'b0;
      if (bus.p0_req && bus.p1_req) begin
         if (cnt_r < CNT_MAX) begin
            winner_s = last_r;
         end else begin
            winner_s = ~last_r;
         end
      end else if (bus.p1_req) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
   end

   // One-hot grants and RAM drive muxed from the winner's fields.
   // When nothing is granted, the RAM controls are driven to zero.
   always_comb begin
      bus.p0_gnt    = any_s & ~winner_s;
      bus.p1_gnt    = any_s &  winner_s;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = {ADDR_WIDTH{1'b0}};
      bus.ram_wdata = {DATA_WIDTH{1'b0}};
      if (any_s) begin
         if (winner_s) begin
            bus.ram_we    = bus.p1_we;
            bus.ram_addr  = bus.p1_addr;
            bus.ram_wdata = bus.p1_wdata;
         end else begin
            bus.ram_we    = bus.p0_we;
            bus.ram_addr  = bus.p0_addr;
            bus.ram_wdata = bus.p0_wdata;
         end
      end else begin
         bus.ram_we    = 1'b0;
         bus.ram_addr  = {ADDR_WIDTH{1'b0}};
         bus.ram_wdata = {DATA_WIDTH{1'b0}};
      end
   end

   // Fairness state and pending-read tracking.
   // An idle cycle saturates cnt_r, so the next tie goes to the other port.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r    <= 1'b1;
         cnt_r     <= CNT_MAX;
         rd_pend_r <= 2'b00;
      end else if (any_s) begin
         if (winner_s == last_r) begin
            cnt_r <= (cnt_r < CNT_MAX) ? (cnt_r + CNT_ONE) : CNT_MAX;
         end else begin
            last_r <= winner_s;
            cnt_r  <= CNT_ONE;
         end
         rd_pend_r[0] <= bus.p0_gnt & ~bus.p0_we;
         rd_pend_r[1] <= bus.p1_gnt & ~bus.p1_we;
      end else begin
         cnt_r     <= CNT_MAX;
         rd_pend_r <= 2'b00;
      end
   end

   // Read responses. rvalid is masked while rst is high, so a read accepted
   // just before reset is never reported.
   always_comb begin
      bus.p0_rvalid = rd_pend_r[0] & ~rst;
      bus.p1_rvalid = rd_pend_r[1] & ~rst;
      bus.p0_rdata  = bus.ram_rdata;
      bus.p1_rdata  = bus.ram_rdata;
   end
endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// tb_ram_arbiter
// Directed, table-driven bench for ram_arbiter.
// Instance "a" (MAX_BURST=4) runs against a behavioural one-cycle RAM and
// is driven from a vector table. Instance "b" (MAX_BURST=1) is exercised by
// a hand-written alternation sequence.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
   ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();

   ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a.slave));
   ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b.slave));

   assign bus_b.ram_rdata = 32'h0000_0000;

   // Behavioural RAM: one-cycle read latency, and old data on a write cycle.
   // Addresses that were never written read back a fixed pattern.
   logic [31:0] mem [256];
   bit          written [256];

   function automatic logic [31:0] pat(input logic [7:0] a);
      return 32'hA5A5_0000 | {24'h00_0000, a};
   endfunction

   always @(posedge clk) begin
      if (bus_a.ram_we) begin
         mem[bus_a.ram_addr]     <= bus_a.ram_wdata;
         written[bus_a.ram_addr] <= 1'b1;
      end
      bus_a.ram_rdata <= written[bus_a.ram_addr] ? mem[bus_a.ram_addr]
                                                 : pat(bus_a.ram_addr);
   end

   typedef struct {
      logic        rst;
      logic        r0, w0;
      logic [7:0]  a0;
      logic [31:0] d0;
      logic        r1, w1;
      logic [7:0]  a1;
      logic [31:0] d1;
      logic        g0, g1, rv0, rv1;
      logic [31:0] rd0, rd1;
   } vec_t;

   vec_t vecs [64];
   int   nv = 0;

   task automatic add(input logic rst, input logic r0, input logic w0,
                      input logic [7:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [7:0] a1, input logic [31:0] d1,
                      input logic g0, input logic g1,
                      input logic rv0, input logic rv1,
                      input logic [31:0] rd0, input logic [31:0] rd1);
      vecs[nv] = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, rv0, rv1, rd0, rd1};
      nv++;
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g0k, g0p, g1p;
      // Reset, two cycles with nothing requested.
      add(1'b1, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b1, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      // Continuous contention, both reading: p0 gets 4, then p1 gets 4, then p0 gets 4.
      for (int k = 1; k <= 12; k++) begin
         g0k = (k <= 4) || (k >= 9);
         g0p = (k > 1) && ((k - 1 <= 4) || (k - 1 >= 9));
         g1p = (k - 1 >= 5) && (k - 1 <= 8);
         add(1'b0, 1'b1,1'b0,8'h03,32'h0, 1'b1,1'b0,8'h05,32'h0,
             g0k, !g0k, g0p, g1p, pat(8'h03), pat(8'h05));
      end
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, pat(8'h03),32'h0);
      // p0 writes 0x10, then reads it back and sees the new data.
      add(1'b0, 1'b1,1'b1,8'h10,32'hDEADBEEF, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b1,1'b0,8'h10,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0);
      // Alternating reads, p1 addr 7 then p0 addr 8, then a p1 write that yields no rvalid.
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h07,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b1,1'b0,8'h08,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h0,pat(8'h07));
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b1,8'h07,32'h12345678, 1'b0,1'b1,1'b1,1'b0, pat(8'h08),32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      // Lone p1 requester for 10 cycles; then p0 wins the first tie.
      for (int k = 0; k < 10; k++) begin
         add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h20,32'h0,
             1'b0,1'b1,1'b0,(k > 0), 32'h0,pat(8'h20));
      end
      add(1'b0, 1'b1,1'b0,8'h21,32'h0, 1'b1,1'b0,8'h20,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h0,pat(8'h20));
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, pat(8'h21),32'h0);
      // Read, then reset the next cycle: rvalid is suppressed and stays low after reset.
      add(1'b0, 1'b1,1'b0,8'h09,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b1, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      // The first tie after reset goes to p0.
      add(1'b0, 1'b1,1'b0,8'h01,32'h0, 1'b1,1'b0,8'h02,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, pat(8'h01),32'h0);
      // Read granted during reset: grant is still computed, but no rvalid follows.
      add(1'b1, 1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h04,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);
      // p1 loses a tie, then drops req: nothing is issued for it.
      add(1'b0, 1'b1,1'b0,8'h30,32'h0, 1'b1,1'b0,8'h31,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b1,1'b0, pat(8'h30),32'h0);
      add(1'b0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0);

      {bus_a.p0_req, bus_a.p0_we, bus_a.p1_req, bus_a.p1_we} = 4'b0000;
      bus_a.p0_addr = 8'h00; bus_a.p1_addr = 8'h00;
      bus_a.p0_wdata = 32'h0; bus_a.p1_wdata = 32'h0;
      {bus_b.p0_req, bus_b.p0_we, bus_b.p1_req, bus_b.p1_we} = 4'b0000;
      bus_b.p0_addr = 8'h00; bus_b.p1_addr = 8'h00;
      bus_b.p0_wdata = 32'h0; bus_b.p1_wdata = 32'h0;

      for (int i = 0; i < nv; i++) begin
         @(posedge clk);
         #1;
         rst_a          = vecs[i].rst;
         bus_a.p0_req   = vecs[i].r0;
         bus_a.p0_we    = vecs[i].w0;
         bus_a.p0_addr  = vecs[i].a0;
         bus_a.p0_wdata = vecs[i].d0;
         bus_a.p1_req   = vecs[i].r1;
         bus_a.p1_we    = vecs[i].w1;
         bus_a.p1_addr  = vecs[i].a1;
         bus_a.p1_wdata = vecs[i].d1;
         @(negedge clk);
         check("p0_gnt",    i, {31'h0, bus_a.p0_gnt},    {31'h0, vecs[i].g0});
         check("p1_gnt",    i, {31'h0, bus_a.p1_gnt},    {31'h0, vecs[i].g1});
         check("p0_rvalid", i, {31'h0, bus_a.p0_rvalid}, {31'h0, vecs[i].rv0});
         check("p1_rvalid", i, {31'h0, bus_a.p1_rvalid}, {31'h0, vecs[i].rv1});
         if (vecs[i].rv0) check("p0_rdata", i, bus_a.p0_rdata, vecs[i].rd0);
         if (vecs[i].rv1) check("p1_rdata", i, bus_a.p1_rdata, vecs[i].rd1);
      end

      // MAX_BURST=1: strict alternation under contention, starting with p0.
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      bus_b.p0_req = 1'b1; bus_b.p0_addr = 8'h03;
      bus_b.p1_req = 1'b1; bus_b.p1_addr = 8'h05;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         @(negedge clk);
         check("b_alt_p0_gnt", 100 + k, {31'h0, bus_b.p0_gnt}, {31'h0, (k % 2 == 0)});
         check("b_alt_p1_gnt", 100 + k, {31'h0, bus_b.p1_gnt}, {31'h0, (k % 2 == 1)});
      end
      // One idle cycle, then a tie: p0 wins because p1 was granted last.
      @(posedge clk);
      #1;
      bus_b.p0_req = 1'b0; bus_b.p1_req = 1'b0;
      @(negedge clk);
      check("b_idle_p0_gnt", 106, {31'h0, bus_b.p0_gnt}, 32'h0);
      check("b_idle_p1_gnt", 106, {31'h0, bus_b.p1_gnt}, 32'h0);
      @(posedge clk);
      #1;
      bus_b.p0_req = 1'b1; bus_b.p1_req = 1'b1;
      @(negedge clk);
      check("b_tie_p0_gnt", 107, {31'h0, bus_b.p0_gnt}, 32'h1);
      check("b_tie_p1_gnt", 107, {31'h0, bus_b.p1_gnt}, 32'h0);
      @(posedge clk);
      #1;
      bus_b.p0_req = 1'b0; bus_b.p1_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
